// File: rtl/serial_descrambler_if.sv
// Serial bit-stream interface for serial_descrambler: one scrambled bit in, one descrambled bit out.
// SERIAL_DESCRAMBLER_BYPASS_EN adds the bypass control signal.
interface serial_descrambler_if;
    logic enable;
    logic resync;
    logic bit_in;
    logic bit_out;
    logic out_valid;
    logic locked;
`ifdef SERIAL_DESCRAMBLER_BYPASS_EN
    logic bypass;

    modport master (
        output enable, resync, bit_in, bypass,
        input  bit_out, out_valid, locked
    );
    modport slave (
        input  enable, resync, bit_in, bypass,
        output bit_out, out_valid, locked
    );
`else
    modport master (
        output enable, resync, bit_in,
        input  bit_out, out_valid, locked
    );
    modport slave (
        input  enable, resync, bit_in,
        output bit_out, out_valid, locked
    );
`endif
endinterface

// File: rtl/serial_descrambler.sv
// Self-synchronising descrambler for G(x) = x^TAP_A + x^TAP_B + 1 with fill/lock qualification.
// Optional feature: SERIAL_DESCRAMBLER_BYPASS_EN adds a bypass input that passes bit_in straight through.
module serial_descrambler #(
    parameter int TAP_A = 58,
    parameter int TAP_B = 39,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_descrambler_if.slave bus
);

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TAP_A - 1);
    localparam logic [CNT_W-1:0] FILL_SAT  = CNT_W'(TAP_A);

    // History of received (scrambled) bits, newest in bit 0.
    logic [TAP_A-1:0] s;
    logic [CNT_W-1:0] fill_cnt;
    logic [0:0]       state;
    logic             bit_out_q;
    logic             out_valid_q;

    logic descr_bit;
    logic next_bit;
    logic bypass_on;

`ifdef SERIAL_DESCRAMBLER_BYPASS_EN
    assign bypass_on = bus.bypass;
`else
    assign bypass_on = 1'b0;
`endif

    assign descr_bit = bus.bit_in ^ s[TAP_A-1] ^ s[TAP_B-1];
    assign next_bit  = bypass_on ? bus.bit_in : descr_bit;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s           <= '0;
            fill_cnt    <= '0;
            state       <= ST_FILL;
            bit_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.resync) begin
            // Concurrent enable bit is dropped; bit_out keeps its last value.
            s           <= '0;
            fill_cnt    <= '0;
            state       <= ST_FILL;
            out_valid_q <= 1'b0;
        end else if (bus.enable) begin
            s           <= {s[TAP_A-2:0], bus.bit_in};
            bit_out_q   <= next_bit;
            out_valid_q <= bypass_on || (state == ST_LOCKED);
            if (fill_cnt != FILL_SAT) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if ((state == ST_FILL) && (fill_cnt == FILL_LAST)) begin
                state <= ST_LOCKED;
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.bit_out   = bit_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.locked    = (state == ST_LOCKED);

endmodule

// File: tb/tb_serial_descrambler.sv
// Scoreboard bench for serial_descrambler: a scrambler model feeds the DUT and the source bits are the reference.
// Expected results are queued at drive time and compared one cycle later.
module tb_serial_descrambler;

    logic clk;
    logic rst_n;

    serial_descrambler_if bus ();

    serial_descrambler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  v;
        logic  b;
        logic  chk_b;
        logic  l;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    logic [57:0] scr;
    logic        last_b;

    function automatic logic scramble(input logic d);
        logic o;
        o   = d ^ scr[57] ^ scr[38];
        scr = {scr[56:0], o};
        return o;
    endfunction

    task automatic step(input string tag, input logic rst_v, input logic en, input logic rs,
                        input logic din, input logic exp_v, input logic exp_b,
                        input logic chk_b, input logic exp_l);
        exp_t e;
        @(negedge clk);
        rst_n      = rst_v;
        bus.enable = en;
        bus.resync = rs;
        bus.bit_in = din;
        sb.push_back('{tag, exp_v, exp_b, chk_b, exp_l});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (bus.out_valid !== e.v) begin
            bad++;
            $display("FAIL %s out_valid: got %b want %b", e.tag, bus.out_valid, e.v);
        end
        total++;
        if (bus.locked !== e.l) begin
            bad++;
            $display("FAIL %s locked: got %b want %b", e.tag, bus.locked, e.l);
        end
        if (e.chk_b) begin
            total++;
            if (bus.bit_out !== e.b) begin
                bad++;
                $display("FAIL %s bit_out: got %b want %b", e.tag, bus.bit_out, e.b);
            end
        end
    endtask

    task automatic apply_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            step(tag, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        scr    = '0;
        last_b = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_loopback();
        logic src;
        apply_reset("loop_rst");
        for (int n = 1; n <= 1000; n++) begin
            src = 1'($urandom);
            step($sformatf("loop bit %0d", n), 1'b1, 1'b1, 1'b0, scramble(src),
                 n >= 59, src, 1'b1, n >= 58);
        end
    endtask

    task automatic test_seeded();
        logic src;
        apply_reset("seed_rst");
        scr = '1;
        for (int n = 1; n <= 1000; n++) begin
            src = 1'($urandom);
            step($sformatf("seed bit %0d", n), 1'b1, 1'b1, 1'b0, scramble(src),
                 n >= 59, src, n >= 59, n >= 58);
        end
    endtask

    task automatic test_enable_duty();
        logic src;
        int   k;
        apply_reset("duty_rst");
        k = 0;
        for (int c = 0; c < 2000 && k < 150; c++) begin
            if ($urandom_range(1, 0) == 1) begin
                k++;
                src = 1'($urandom);
                step($sformatf("duty bit %0d", k), 1'b1, 1'b1, 1'b0, scramble(src),
                     k >= 59, src, 1'b1, k >= 58);
                last_b = src;
            end else begin
                step($sformatf("duty idle after %0d", k), 1'b1, 1'b0, 1'b0, 1'($urandom),
                     1'b0, last_b, 1'b1, k >= 58);
            end
        end
    endtask

    task automatic test_resync();
        logic src;
        int   k;
        apply_reset("rsy_rst");
        k = 0;
        for (int n = 1; n <= 500; n++) begin
            src = 1'($urandom);
            if (n == 300) begin
                k = 0;
                step("rsy drop 300", 1'b1, 1'b1, 1'b1, scramble(src),
                     1'b0, last_b, 1'b1, 1'b0);
            end else begin
                k++;
                step($sformatf("rsy bit %0d", n), 1'b1, 1'b1, 1'b0, scramble(src),
                     k >= 59, src, k >= 59 || n < 300, k >= 58);
                last_b = src;
            end
        end
    endtask

    task automatic test_error_prop();
        logic src;
        logic rx;
        logic hit;
        apply_reset("err_rst");
        for (int n = 1; n <= 700; n++) begin
            src = 1'($urandom);
            rx  = scramble(src) ^ (n == 500);
            hit = (n == 500) || (n == 539) || (n == 558);
            step($sformatf("err bit %0d", n), 1'b1, 1'b1, 1'b0, rx,
                 n >= 59, src ^ hit, 1'b1, n >= 58);
        end
    endtask

`ifdef SERIAL_DESCRAMBLER_BYPASS_EN
    task automatic test_bypass();
        logic din;
        apply_reset("byp_rst");
        bus.bypass = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            din = 1'($urandom);
            step($sformatf("byp bit %0d", n), 1'b1, 1'b1, 1'b0, din, 1'b1, din, 1'b1, 1'b0);
        end
        bus.bypass = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.resync = 1'b0;
        bus.bit_in = 1'b0;
`ifdef SERIAL_DESCRAMBLER_BYPASS_EN
        bus.bypass = 1'b0;
`endif
        total  = 0;
        bad    = 0;
        scr    = '0;
        last_b = 1'b0;

        test_reset();
        test_loopback();
        test_seeded();
        test_enable_duty();
        test_resync();
        test_error_prop();
`ifdef SERIAL_DESCRAMBLER_BYPASS_EN
        test_bypass();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
